// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. On an accepted start request it captures two
// WIDTH-bit operands and feeds them LSB first through a single 1-bit
// full_adder. A registered carry links successive bit positions, so one cell
// does the work of a WIDTH-bit ripple adder in WIDTH clock cycles.
//
// Optional feature macro: SUBTRACT_EN
//   Defined   : a captured sub = 1 computes a - b (two's complement). cout is
//               then a no-borrow flag, 1 when a >= b unsigned.
//   Undefined : sub is ignored and no subtract logic is built.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      operation request, sampled only while idle
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   sub    in   1      subtract request, captured with the operands
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  result register, holds between operations
//   cout   out  1      final carry (no-borrow flag when subtracting)
// -----------------------------------------------------------------------------

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;

  assign last_bit = (cnt == LAST_CNT);

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

`ifndef SUBTRACT_EN
  // sub stays on the port list so the top-level wiring is identical in both
  // builds; in this build it deliberately drives nothing.
  logic unused_sub;
  assign unused_sub = sub;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, bit-serial shift, result commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            work <= '0;
            cnt  <= '0;
`ifdef SUBTRACT_EN
            // a - b = a + ~b + 1: invert B and seed the carry with the +1.
            b_sh  <= sub ? ~b : b;
            carry <= sub;
`else
            b_sh  <= b;
            carry <= 1'b0;
`endif
          end
        end
        RUN: begin
          // Each new sum bit enters at the MSB; after WIDTH shifts bit 0
          // has walked down to position 0.
          work  <= {fa_s, work[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_c;
          if (last_bit) begin
            sum  <= {fa_s, work[WIDTH-1:1]};
            cout <= fa_c;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed self-checking bench for serial_add_ctrl at WIDTH = 4. Expected
// values are hand-computed constants; the bench keeps its own copy of the
// last committed result to check that sum/cout hold between operations.
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_serial_add_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int errs;
  int checks;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full operation with a start pulse; checks the whole timeline.
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic sv, input logic [3:0] es, input logic ec);
    a = av; b = bv; sub = sv; start = 1'b1;
    tick;                                   // edge 0: accepted
    start = 1'b0;
    chk({tag, ".busy0"}, busy, 1);
    chk({tag, ".done0"}, done, 0);
    for (int i = 1; i < WIDTH; i++) begin
      tick;
      chk($sformatf("%s.busy%0d", tag, i), busy, 1);
      chk($sformatf("%s.hold%0d", tag, i), {cout, sum}, {exp_cout, exp_sum});
    end
    tick;                                   // edge WIDTH: commit
    exp_sum = es; exp_cout = ec;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    tick;
    chk({tag, ".done_fall"}, done, 0);
    chk({tag, ".sum_hold"}, sum, es);
  endtask

  logic [3:0] ca [3];
  logic [3:0] cb [3];
  logic [3:0] cs [3];
  logic       cc [3];

  initial begin
    errs = 0; checks = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;

    // Reset state
    tick; tick;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum",  sum, 0);
    chk("rst.cout", cout, 0);
    rst_n = 1'b1;
    tick;
    chk("idle.busy", busy, 0);

    // Add without carry, then overflow
    run_op("add", 4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0);
    run_op("ovf", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
    run_op("mix", 4'b1010, 4'b0111, 1'b0, 4'b0001, 1'b1);

    // Ignored start during RUN
    a = 4'b0011; b = 4'b0101; start = 1'b1;
    tick;                                   // edge 0
    start = 1'b0;
    tick; tick;                             // edges 1,2
    a = 4'b0001; b = 4'b0001; start = 1'b1;
    tick;                                   // edge 3: must be ignored
    start = 1'b0;
    chk("ign.busy3", busy, 1);
    tick;                                   // edge 4
    chk("ign.done", done, 1);
    chk("ign.sum",  sum, 4'b1000);
    chk("ign.cout", cout, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("ign.nodone%0d", i), done, 0);
      chk($sformatf("ign.nobusy%0d", i), busy, 0);
    end
    chk("ign.sum_hold", sum, 4'b1000);

    // Continuous start: one result every WIDTH+2 cycles
    ca[0] = 4'b0001; cb[0] = 4'b0010; cs[0] = 4'b0011; cc[0] = 1'b0;
    ca[1] = 4'b1100; cb[1] = 4'b0110; cs[1] = 4'b0010; cc[1] = 1'b1;
    ca[2] = 4'b0111; cb[2] = 4'b0111; cs[2] = 4'b1110; cc[2] = 1'b0;
    a = ca[0]; b = cb[0]; start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick;                                 // edge i (relative to first accept)
      if (i % 6 == 0 && i / 6 + 1 < 3) begin
        a = ca[i / 6 + 1]; b = cb[i / 6 + 1];
      end
      chk($sformatf("cont.done%0d", i), done, (i % 6 == 4) ? 1 : 0);
      chk($sformatf("cont.busy%0d", i), busy, (i % 6 <= 3) ? 1 : 0);
      if (i % 6 == 4) begin
        chk($sformatf("cont.sum%0d", i / 6), {cout, sum}, {cc[i / 6], cs[i / 6]});
      end
    end
    start = 1'b0;
    tick; tick; tick; tick; tick; tick;     // drain any accepted op
    chk("cont.idle", busy, 0);

    // Reset in the middle of 1111 + 0001 (reset edge processes bit 2)
    a = 4'b1111; b = 4'b0001; start = 1'b1;
    tick;                                   // edge 0
    start = 1'b0;
    tick; tick;                             // edges 1,2
    rst_n = 1'b0;
    tick;                                   // edge 3: reset
    rst_n = 1'b1;
    exp_sum = '0; exp_cout = 1'b0;
    chk("mrst.busy", busy, 0);
    chk("mrst.done", done, 0);
    chk("mrst.sum",  sum, 0);
    chk("mrst.cout", cout, 0);
    tick;
    chk("mrst.idle", {busy, done}, 2'b00);
    run_op("post", 4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0);

    // Subtract request
`ifdef SUBTRACT_EN
    run_op("sub1", 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1);
    run_op("sub2", 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0);
    run_op("sub3", 4'b0110, 4'b0110, 1'b1, 4'b0000, 1'b1);
`else
    run_op("nosub", 4'b0101, 4'b0011, 1'b1, 4'b1000, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
